exec_stage_pipe: RTL

//  Registered Y86 execute stage: ALU, condition-code register (ZF/SF/OF), jump/cmov condition evaluation.

---
 rtl/exec_stage_pipe_pkg.sv | 62 ++++++
 rtl/exec_stage_pipe_if.sv | 42 ++++
 rtl/exec_stage_pipe_alu.sv | 54 +++++
 rtl/exec_stage_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/exec_stage_pipe_pkg.sv
// Y86 encodings, status codes and condition-code type shared by the execute stage.
// Also holds the jump/cmov condition evaluator.
package y86_defs;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Unknown condition codes evaluate false; the caller flags them as INS.
    function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
        logic r;
        case (ifun)
            C_ALWAYS: r = 1'b1;
            C_LE:     r = (cc.sf ^ cc.of) | cc.zf;
            C_L:      r = cc.sf ^ cc.of;
            C_E:      r = cc.zf;
            C_NE:     r = ~cc.zf;
            C_GE:     r = ~(cc.sf ^ cc.of);
            C_G:      r = ~(cc.sf ^ cc.of) & ~cc.zf;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_stage_pipe_if.sv
// Handshake bundle between the E register, the execute stage and the memory stage.
// master drives instructions and consumes results; slave is the execute stage.
interface exec_stage_pipe_if #(parameter int WORD_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    logic [WORD_W-1:0] in_valA;
    logic [WORD_W-1:0] in_valB;
    logic [WORD_W-1:0] in_valC;
    logic [3:0]        in_dstE;
    logic [3:0]        in_dstM;
    logic [2:0]        in_stat;
    logic              exc_block;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic              out_Cnd;
    logic [WORD_W-1:0] out_valE;
    logic [WORD_W-1:0] out_valA;
    logic [3:0]        out_dstE;
    logic [3:0]        out_dstM;
    logic [2:0]        out_stat;
    logic [2:0]        cc_o;

    modport master (
        output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC,
               in_dstE, in_dstM, in_stat, exc_block, flush, out_ready,
        input  in_ready, out_valid, out_icode, out_Cnd, out_valE, out_valA,
               out_dstE, out_dstM, out_stat, cc_o
    );

    modport slave (
        input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC,
               in_dstE, in_dstM, in_stat, exc_block, flush, out_ready,
        output in_ready, out_valid, out_icode, out_Cnd, out_valE, out_valA,
               out_dstE, out_dstM, out_stat, cc_o
    );

endinterface

// File: rtl/exec_stage_pipe_alu.sv
// Combinational execute ALU: selects valE per icode and derives ZF/SF/OF.
// Flags are only meaningful for OPL; the caller decides whether to latch them.
module exec_alu
    import y86_defs::*;
#(
    parameter int WORD_W     = 32,
    parameter int STACK_STEP = WORD_W / 8
) (
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [WORD_W-1:0] val_a,
    input  logic [WORD_W-1:0] val_b,
    input  logic [WORD_W-1:0] val_c,
    output logic [WORD_W-1:0] res,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    localparam int MSB = WORD_W - 1;
    localparam logic [WORD_W-1:0] STEP = WORD_W'(STACK_STEP);

    always_comb begin
        res = '0;
        of  = 1'b0;
        case (icode)
            I_RRMOVL:          res = val_a;
            I_IRMOVL:          res = val_c;
            I_RMMOVL, I_MRMOVL: res = val_b + val_c;
            I_OPL: begin
                case (ifun)
                    F_ADD: begin
                        res = val_b + val_a;
                        of  = (val_a[MSB] == val_b[MSB]) && (res[MSB] != val_a[MSB]);
                    end
                    F_SUB: begin
                        res = val_b - val_a;
                        of  = (val_a[MSB] != val_b[MSB]) && (res[MSB] != val_b[MSB]);
                    end
                    F_AND:   res = val_a & val_b;
                    F_XOR:   res = val_a ^ val_b;
                    default: res = '0;
                endcase
            end
            I_CALL, I_PUSHL:   res = val_b - STEP;
            I_RET, I_POPL:     res = val_b + STEP;
            default:           res = '0;
        endcase
    end

    assign zf = (res == '0);
    assign sf = res[MSB];

endmodule

// File: rtl/exec_stage_pipe.sv
// Y86 execute stage: ALU, condition-code register, jump/cmov condition and the
// E->M pipeline register with valid/ready handshake and flush.
module exec_stage_pipe
    import y86_defs::*;
#(
    parameter int WORD_W     = 32,
    parameter int STACK_STEP = WORD_W / 8
) (
    input logic             clk,
    input logic             rst,
    exec_stage_pipe_if.slave e
);

    cc_t               cc;
    logic [WORD_W-1:0] alu_res;
    logic              alu_zf;
    logic              alu_sf;
    logic              alu_of;
    logic              accept;
    logic              is_cond;
    logic              cnd;
    logic              bad_fun;
    logic              cc_we;
    logic [2:0]        stat_next;
    logic [3:0]        dst_e_next;

    exec_alu #(
        .WORD_W    (WORD_W),
        .STACK_STEP(STACK_STEP)
    ) u_alu (
        .icode(e.in_icode),
        .ifun (e.in_ifun),
        .val_a(e.in_valA),
        .val_b(e.in_valB),
        .val_c(e.in_valC),
        .res  (alu_res),
        .zf   (alu_zf),
        .sf   (alu_sf),
        .of   (alu_of)
    );

    assign e.in_ready = ~e.out_valid | e.out_ready;
    assign accept     = e.in_valid & e.in_ready & ~e.flush;

    // Condition uses the CC as it stands before this instruction's edge.
    assign is_cond    = (e.in_icode == I_RRMOVL) | (e.in_icode == I_JXX);
    assign cnd        = is_cond & cond_eval(cc, e.in_ifun);
    assign bad_fun    = ((e.in_icode == I_OPL) & (e.in_ifun > F_XOR)) |
                        (is_cond & (e.in_ifun > C_G));
    assign stat_next  = ((e.in_stat == S_AOK) && bad_fun) ? S_INS : e.in_stat;
    assign dst_e_next = ((e.in_icode == I_RRMOVL) && !cnd) ? RNONE : e.in_dstE;

    assign cc_we = accept && (e.in_icode == I_OPL) && (e.in_ifun <= F_XOR) &&
                   (e.in_stat == S_AOK) && !e.exc_block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc <= CC_RESET;
        end else if (cc_we) begin
            cc <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
        end
    end

    assign e.cc_o = cc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e.out_valid <= 1'b0;
            e.out_icode <= I_NOP;
            e.out_Cnd   <= 1'b0;
            e.out_valE  <= '0;
            e.out_valA  <= '0;
            e.out_dstE  <= RNONE;
            e.out_dstM  <= RNONE;
            e.out_stat  <= S_AOK;
        end else if (e.flush) begin
            e.out_valid <= 1'b0;
            e.out_icode <= I_NOP;
            e.out_Cnd   <= 1'b0;
            e.out_valE  <= '0;
            e.out_valA  <= '0;
            e.out_dstE  <= RNONE;
            e.out_dstM  <= RNONE;
            e.out_stat  <= S_AOK;
        end else if (e.in_ready) begin
            e.out_valid <= e.in_valid;
            if (e.in_valid) begin
                e.out_icode <= e.in_icode;
                e.out_Cnd   <= cnd;
                e.out_valE  <= alu_res;
                e.out_valA  <= e.in_valA;
                e.out_dstE  <= dst_e_next;
                e.out_dstM  <= e.in_dstM;
                e.out_stat  <= stat_next;
            end
        end
    end

endmodule
